// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT datapath.
// Packed complex words carry {re, im} as two signed halves.
package fft_pkg;

  localparam int H = 16;
  localparam int TW_FRAC_DEF = 14;
  localparam int TW_ONE = 1 << TW_FRAC_DEF;

  typedef logic [2*H-1:0] cplx_t;
  typedef logic signed [H-1:0] comp_t;

  function automatic comp_t re(input cplx_t x);
    return x[2*H-1:H];
  endfunction

  function automatic comp_t im(input cplx_t x);
    return x[H-1:0];
  endfunction

  function automatic cplx_t pack(input comp_t r, input comp_t i);
    return {r, i};
  endfunction

  localparam logic signed [2*H+1:0] SAT_HI =
    {{(H+3){1'b0}}, {(H-1){1'b1}}};
  localparam logic signed [2*H+1:0] SAT_LO =
    {{(H+3){1'b1}}, {(H-1){1'b0}}};

  // MSB of the result flags that clipping happened
  function automatic logic [H:0] sat_h(
    input logic signed [2*H+1:0] x
  );
    logic [H:0] r;
    if (x > SAT_HI) r = {1'b1, SAT_HI[H-1:0]};
    else if (x < SAT_LO) r = {1'b1, SAT_LO[H-1:0]};
    else r = {1'b0, x[H-1:0]};
    return r;
  endfunction

endpackage

// File: rtl/ibutterfly_pipe_cmul_conj.sv
// Registered multiply by conj(W): full-precision products,
// then round-half-up and saturate into the output register.
module cmul_conj
  import fft_pkg::*;
#(
  parameter int TW_FRAC = TW_FRAC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ld,
  input  logic signed [H:0] d_re,
  input  logic signed [H:0] d_im,
  input  cplx_t             w,
  output cplx_t             b,
  output logic              ovf
);

  localparam int PW = 2*H+2;
  localparam logic signed [PW-1:0] RND =
    PW'(1) << (TW_FRAC-1);

  logic signed [PW-1:0] pr_q, pr_d;
  logic signed [PW-1:0] pi_q, pi_d;
  cplx_t                b_q, b_d;
  logic                 ovf_q, ovf_d;

  comp_t                wr, wi;
  logic signed [PW-1:0] xr, xi;
  logic [H:0]           sr, si;

  always_comb begin
    wr = re(w);
    wi = im(w);
    pr_d = pr_q;
    pi_d = pi_q;
    b_d = b_q;
    ovf_d = ovf_q;
    if (en) begin
      pr_d = d_re * wr + d_im * wi;
      pi_d = d_im * wr - d_re * wi;
    end
    xr = (pr_q + RND) >>> TW_FRAC;
    xi = (pi_q + RND) >>> TW_FRAC;
    sr = sat_h(xr);
    si = sat_h(xi);
    if (ld) begin
      b_d = pack(sr[H-1:0], si[H-1:0]);
      ovf_d = sr[H] | si[H];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q <= '0;
      pi_q <= '0;
      b_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pr_q <= pr_d;
      pi_q <= pi_d;
      b_q <= b_d;
      ovf_q <= ovf_d;
    end
  end

  assign b = b_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/ibutterfly_pipe.sv
// Pipelined radix-2 inverse butterfly: A = (P+M)/2,
// B = conj(W)*(P-M)/2, three stages, global stall enable.
module ibutterfly_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH = 2*H,
  parameter int TW_FRAC = TW_FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH-1:0] w_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             ovf
);

  logic en, ld3;
  comp_t pr, pi, mr, mi;

  logic v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
  logic signed [H:0] sr_q, sr_d, si_q, si_d;
  logic signed [H:0] dr_q, dr_d, di_q, di_d;
  cplx_t w1_q, w1_d;
  comp_t a2r_q, a2r_d, a2i_q, a2i_d;
  cplx_t ao_q, ao_d;

  logic signed [H:0] d_re, d_im;

  always_comb begin
    en = !ov_q || out_ready;
    ld3 = en && v2_q;
    pr = re(p_in);
    pi = im(p_in);
    mr = re(m_in);
    mi = im(m_in);
    v1_d = v1_q;
    v2_d = v2_q;
    ov_d = ov_q;
    sr_d = sr_q;
    si_d = si_q;
    dr_d = dr_q;
    di_d = di_q;
    w1_d = w1_q;
    a2r_d = a2r_q;
    a2i_d = a2i_q;
    ao_d = ao_q;
    if (en) begin
      v1_d = in_valid;
      sr_d = {pr[H-1], pr} + {mr[H-1], mr};
      si_d = {pi[H-1], pi} + {mi[H-1], mi};
      dr_d = {pr[H-1], pr} - {mr[H-1], mr};
      di_d = {pi[H-1], pi} - {mi[H-1], mi};
      w1_d = w_in;
      v2_d = v1_q;
      a2r_d = comp_t'(sr_q >>> 1);
      a2i_d = comp_t'(si_q >>> 1);
      ov_d = v2_q;
    end
    // bubbles leave the last result on the outputs
    if (ld3) ao_d = pack(a2r_q, a2i_q);
    d_re = dr_q >>> 1;
    d_im = di_q >>> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      ov_q <= 1'b0;
      sr_q <= '0;
      si_q <= '0;
      dr_q <= '0;
      di_q <= '0;
      w1_q <= '0;
      a2r_q <= '0;
      a2i_q <= '0;
      ao_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      ov_q <= ov_d;
      sr_q <= sr_d;
      si_q <= si_d;
      dr_q <= dr_d;
      di_q <= di_d;
      w1_q <= w1_d;
      a2r_q <= a2r_d;
      a2i_q <= a2i_d;
      ao_q <= ao_d;
    end
  end

  cmul_conj #(
    .TW_FRAC(TW_FRAC)
  ) u_cmul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .ld   (ld3),
    .d_re (d_re),
    .d_im (d_im),
    .w    (w1_q),
    .b    (b_out),
    .ovf  (ovf)
  );

  assign in_ready = en && rst_n;
  assign out_valid = ov_q;
  assign a_out = ao_q;

endmodule

// File: tb/tb_ibutterfly_pipe.sv
// Bench for ibutterfly_pipe: directed vectors, stalls, reset,
// and forward/inverse round trips against an arithmetic model.
module tb_ibutterfly_pipe;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] p_in = '0;
  logic [31:0] m_in = '0;
  logic [31:0] w_in = '0;
  logic in_ready, out_valid, ovf;
  logic [31:0] a_out, b_out;

  ibutterfly_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .p_in     (p_in),
    .m_in     (m_in),
    .w_in     (w_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .a_out    (a_out),
    .b_out    (b_out),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ovf;
    bit          rt;
    int          ar, ai, br, bi;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_err = 0;
  int n_stall = 0;
  bit cur_rt = 0;
  int cur_ar, cur_ai, cur_br, cur_bi;

  function automatic logic [15:0] clip(input longint v, output bit o);
    longint c;
    c = v;
    o = 0;
    if (v > 32767) begin c = 32767; o = 1; end
    else if (v < -32768) begin c = -32768; o = 1; end
    return c[15:0];
  endfunction

  function automatic exp_t model(input logic [31:0] p, m, w);
    exp_t e;
    longint pr, pi, mr, mi, wr, wi, ar, ai, dr, di, xr, xi;
    bit o1, o2;
    pr = longint'($signed(p[31:16]));
    pi = longint'($signed(p[15:0]));
    mr = longint'($signed(m[31:16]));
    mi = longint'($signed(m[15:0]));
    wr = longint'($signed(w[31:16]));
    wi = longint'($signed(w[15:0]));
    ar = (pr + mr) >>> 1;
    ai = (pi + mi) >>> 1;
    dr = (pr - mr) >>> 1;
    di = (pi - mi) >>> 1;
    xr = (dr * wr + di * wi + 8192) >>> 14;
    xi = (di * wr - dr * wi + 8192) >>> 14;
    e.a = {ar[15:0], ai[15:0]};
    e.b[31:16] = clip(xr, o1);
    e.b[15:0] = clip(xi, o2);
    e.ovf = o1 | o2;
    e.rt = 0;
    e.ar = 0; e.ai = 0; e.br = 0; e.bi = 0;
    return e;
  endfunction

  function automatic bit near(input int x, input int y);
    return (x - y <= 1) && (y - x <= 1);
  endfunction

  always @(negedge rst_n) q.delete();

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !out_ready) begin
        n_vec++;
        n_stall++;
        if (in_ready) begin
          n_err++;
          $display("FAIL stall_in_ready: got %0b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat: a=%h b=%h with nothing pending",
                   a_out, b_out);
        end else begin
          mon_e = q.pop_front();
          if (a_out !== mon_e.a || b_out !== mon_e.b
              || ovf !== mon_e.ovf) begin
            n_err++;
            $display("FAIL beat: got a=%h b=%h ovf=%b want a=%h b=%h ovf=%b",
                     a_out, b_out, ovf, mon_e.a, mon_e.b, mon_e.ovf);
          end
          if (mon_e.rt) begin
            n_vec++;
            if (!near($signed(a_out[31:16]), mon_e.ar)
                || !near($signed(a_out[15:0]), mon_e.ai)
                || !near($signed(b_out[31:16]), mon_e.br)
                || !near($signed(b_out[15:0]), mon_e.bi)) begin
              n_err++;
              $display("FAIL round_trip: got a=%h b=%h want A=(%0d,%0d) B=(%0d,%0d)",
                       a_out, b_out, mon_e.ar, mon_e.ai,
                       mon_e.br, mon_e.bi);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        mon_e = model(p_in, m_in, w_in);
        mon_e.rt = cur_rt;
        mon_e.ar = cur_ar;
        mon_e.ai = cur_ai;
        mon_e.br = cur_br;
        mon_e.bi = cur_bi;
        q.push_back(mon_e);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // called and returning at posedge+1
  task automatic send(input logic [31:0] p, m, w);
    int t;
    bit acc;
    t = 0;
    acc = 0;
    in_valid = 1;
    p_in = p;
    m_in = m;
    w_in = w;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready low for %0d cycles", t);
    end
  endtask

  task automatic single(input string nm, input logic [31:0] p, m, w,
                        input logic [31:0] ea, eb, input logic eo);
    exp_t e;
    int lat;
    e = model(p, m, w);
    check({nm, "_model"}, {e.a, e.b}, {ea, eb});
    send(p, m, w);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'd3);
    check({nm, "_a"}, 64'(a_out), 64'(ea));
    check({nm, "_b"}, 64'(b_out), 64'(eb));
    check({nm, "_ovf"}, 64'(ovf), 64'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] p, m, w;
    int ar, ai, br, bi, wr, wi, tr, ti, k;
    bit stale;

    #1 rst_n = 0;
    #1;
    check("reset_outs", {29'd0, out_valid, ovf, in_ready, a_out},
          64'd0);
    check("reset_b", 64'(b_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    single("unit", 32'h75300FA0, 32'h271007D0, 32'h40000000,
           32'h4E200BB8, 32'h271003E8, 1'b0);
    single("minus_j", 32'h75300FA0, 32'h271007D0, 32'h0000C000,
           32'h4E200BB8, 32'hFC182710, 1'b0);
    single("sat", 32'h75308AD0, 32'h8AD07530, 32'h7FFF7FFF,
           32'h00000000, 32'h00008000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("hold_valid", 64'(out_valid), 64'd0);
    check("hold_outs", {a_out, b_out}, {32'h0, 32'h00008000});
    check("hold_ovf", 64'(ovf), 64'd1);
    single("ovf_clears", 32'h75300FA0, 32'h271007D0, 32'h40000000,
           32'h4E200BB8, 32'h271003E8, 1'b0);

    fork
      begin
        for (int i = 0; i < 6; i++) send($urandom, $urandom, $urandom);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    for (int t = 0; t < 30 && q.size() != 0; t++) @(posedge clk);
    #1;
    check("bp_drained", 64'(q.size()), 64'd0);
    n_vec++;
    if (n_stall == 0) begin
      n_err++;
      $display("FAIL bp_stall_seen: got %0d stall cycles want >0", n_stall);
    end

    send(32'h12345678, 32'h0F0F0F0F, 32'h40000000);
    send(32'h11112222, 32'h33334444, 32'h00004000);
    @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 0;
    #1;
    check("async_reset", {31'd0, out_valid, ovf, a_out},
          64'd0);
    check("async_reset_b", 64'(b_out), 64'd0);
    @(posedge clk);
    #1 rst_n = 1;
    stale = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) stale = 1;
    end
    check("no_stale", 64'(stale), 64'd0);
    single("fresh", 32'h75300FA0, 32'h271007D0, 32'h40000000,
           32'h4E200BB8, 32'h271003E8, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ar = int'($urandom_range(32000)) - 16000;
      ai = int'($urandom_range(32000)) - 16000;
      br = int'($urandom_range(32000)) - 16000;
      bi = int'($urandom_range(32000)) - 16000;
      k = int'($urandom_range(3));
      wr = (k == 0) ? 1 : (k == 1) ? -1 : 0;
      wi = (k == 2) ? 1 : (k == 3) ? -1 : 0;
      tr = wr * br - wi * bi;
      ti = wr * bi + wi * br;
      p = {16'(ar + tr), 16'(ai + ti)};
      m = {16'(ar - tr), 16'(ai - ti)};
      w = {16'(wr * TW_ONE), 16'(wi * TW_ONE)};
      cur_rt = 1;
      cur_ar = ar;
      cur_ai = ai;
      cur_br = br;
      cur_bi = bi;
      send(p, m, w);
    end
    cur_rt = 0;
    for (int t = 0; t < 30 && q.size() != 0; t++) @(posedge clk);
    #1;
    check("final_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
